// File: rtl/aq_djpeg_pkg.sv
// Shared types and coefficient placement for the JPEG decoder transpose buffer.
// The placement function is also used by verification to locate coefficients.
package aq_djpeg_pkg;

    localparam int AQ_DJPEG_CW = 16;

    typedef logic [4:0] blkIdxT;

    typedef struct packed {
        logic       sel;   // 0: RAM X, 1: RAM Y
        logic [4:0] addr;  // word within a bank
    } ramLocT;

    // Columns 0..3 and 4..7 swap RAMs on the lower/upper row halves, so any
    // (c, 7-c) pair in a row and any (r, 7-r) pair in a column split across RAMs.
    function automatic ramLocT coefLoc(input logic [2:0] r, input logic [2:0] k);
        ramLocT loc;
        loc.sel  = r[2] ^ k[2];
        loc.addr = {r[1:0], k};
        return loc;
    endfunction

endpackage

// File: rtl/aq_djpeg_tbuf_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module aq_djpeg_tbuf_ram
    import aq_djpeg_pkg::*;
#(
    parameter int DW = AQ_DJPEG_CW,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [DW-1:0] wrData,
    input  logic          rdEn,
    input  logic [AW-1:0] rdAddr,
    output logic [DW-1:0] rdData
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // The read register doubles as the transpose buffer's output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/aq_djpeg_tbuf.sv
// Multi-bank transpose buffer between the row and column IDCT passes.
// Optional feature: define AQ_DJPEG_TBUF_BYPASS_EN to add a bypass (untransposed) read mode.
module aq_djpeg_tbuf
    import aq_djpeg_pkg::*;
#(
    parameter int DW    = AQ_DJPEG_CW,
    parameter int NBANK = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init,
`ifdef AQ_DJPEG_TBUF_BYPASS_EN
    input  logic                         bypass,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_page,
    input  logic [1:0]                   in_count,
    input  logic [DW-1:0]                in_a,
    input  logic [DW-1:0]                in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_a,
    output logic [DW-1:0]                out_b,
    output logic                         out_last,
    output logic [$clog2(NBANK+1)-1:0]   occ
);

    localparam int BW = $clog2(NBANK);
    localparam int OW = $clog2(NBANK + 1);
    localparam int AW = BW + 5;

    logic [BW-1:0] wBankReg, rBankReg;
    blkIdxT        rdIdxReg;
    logic [OW-1:0] occReg, occNext;
    logic          outValidReg, outLastReg, aSelReg;

    logic          bypassMode;
    logic          wrAccept, wrDone, load, rdDone;
    blkIdxT        wrIdx;
    logic [2:0]    rdJ, rdK;
    ramLocT        wLocA, wLocB, rLocA, rLocB;
    logic [DW-1:0] ramRdData [2];

`ifdef AQ_DJPEG_TBUF_BYPASS_EN
    assign bypassMode = bypass;
`else
    assign bypassMode = 1'b0;
`endif

    assign in_ready  = (occReg != OW'(NBANK));
    assign occ       = occReg;
    assign out_valid = outValidReg;
    assign out_last  = outLastReg;

    // init takes priority over any handshake in the same cycle.
    assign wrIdx    = {in_page, in_count};
    assign wrAccept = in_valid && in_ready && !init;
    assign wrDone   = wrAccept && (wrIdx == 5'd31);
    assign load     = !init && (occReg != '0) && (!outValidReg || out_ready);
    assign rdDone   = load && (rdIdxReg == 5'd31);

    assign wLocA = coefLoc(in_page, {1'b0, in_count});
    assign wLocB = coefLoc(in_page, ~{1'b0, in_count});

    assign rdJ = rdIdxReg[4:2];
    assign rdK = {1'b0, rdIdxReg[1:0]};

    always_comb begin
        rLocA = coefLoc(rdK, rdJ);
        rLocB = coefLoc(~rdK, rdJ);
        if (bypassMode) begin
            rLocA = coefLoc(rdJ, rdK);
            rLocB = coefLoc(rdJ, ~rdK);
        end
    end

    always_comb begin
        occNext = occReg;
        case ({wrDone, rdDone})
            2'b10:   occNext = occReg + OW'(1);
            2'b01:   occNext = occReg - OW'(1);
            default: occNext = occReg;
        endcase
    end

    // gi = 0 is RAM X, gi = 1 is RAM Y; each pair element is steered by its select bit.
    for (genvar gi = 0; gi < 2; gi++) begin : gRam
        logic wrSelA, rdSelA;

        assign wrSelA = (wLocA.sel == 1'(gi));
        assign rdSelA = (rLocA.sel == 1'(gi));

        aq_djpeg_tbuf_ram #(
            .DW(DW),
            .AW(AW)
        ) uRam (
            .clk    (clk),
            .rst    (rst),
            .wrEn   (wrAccept),
            .wrAddr ({wBankReg, (wrSelA ? wLocA.addr : wLocB.addr)}),
            .wrData (wrSelA ? in_a : in_b),
            .rdEn   (load),
            .rdAddr ({rBankReg, (rdSelA ? rLocA.addr : rLocB.addr)}),
            .rdData (ramRdData[gi])
        );
    end

    assign out_a = aSelReg ? ramRdData[1] : ramRdData[0];
    assign out_b = aSelReg ? ramRdData[0] : ramRdData[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wBankReg    <= '0;
            rBankReg    <= '0;
            rdIdxReg    <= '0;
            occReg      <= '0;
            outValidReg <= 1'b0;
            outLastReg  <= 1'b0;
            aSelReg     <= 1'b0;
        end else if (init) begin
            wBankReg    <= '0;
            rBankReg    <= '0;
            rdIdxReg    <= '0;
            occReg      <= '0;
            outValidReg <= 1'b0;
            outLastReg  <= 1'b0;
        end else begin
            occReg <= occNext;
            if (wrDone) begin
                wBankReg <= wBankReg + BW'(1);
            end
            if (rdDone) begin
                rBankReg <= rBankReg + BW'(1);
            end
            if (load) begin
                rdIdxReg    <= rdIdxReg + 5'd1;
                aSelReg     <= rLocA.sel;
                outLastReg  <= (rdIdxReg == 5'd31);
                outValidReg <= 1'b1;
            end else if (out_ready) begin
                outValidReg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aq_djpeg_tbuf.sv
// Self-checking bench for aq_djpeg_tbuf; expected pairs come from a matrix-level model.
// Covers the bypass read mode when AQ_DJPEG_TBUF_BYPASS_EN is defined.
module tb_aq_djpeg_tbuf;
    import aq_djpeg_pkg::*;

    localparam int DW    = AQ_DJPEG_CW;
    localparam int NBANK = 4;
    localparam int OW    = $clog2(NBANK + 1);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pairT;

    logic          clk = 1'b0;
    logic          rst, init, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [2:0]    in_page;
    logic [1:0]    in_count;
    logic [DW-1:0] in_a, in_b, out_a, out_b;
    logic [OW-1:0] occ;
    logic          bypass = 1'b0;

    int   checks = 0;
    int   errors = 0;
    pairT expQ[$];

    always #5 clk = ~clk;

    aq_djpeg_tbuf #(.DW(DW), .NBANK(NBANK)) dut (
        .clk      (clk),
        .rst      (rst),
        .init     (init),
`ifdef AQ_DJPEG_TBUF_BYPASS_EN
        .bypass   (bypass),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_page  (in_page),
        .in_count (in_count),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_last (out_last),
        .occ      (occ)
    );

    // Build an 8x8 block (row-major, element (r,c) at 8r+c) and queue its output pairs.
    task automatic makeBlock(input bit seq, output logic [DW-1:0] v [64]);
        for (int e = 0; e < 64; e++) v[e] = seq ? DW'(e) : DW'($urandom);
        for (int i = 0; i < 32; i++) begin
            int   j;
            int   k;
            pairT p;
            j = i / 4;
            k = i % 4;
            if (bypass) begin
                p.a = v[8*j + k];
                p.b = v[8*j + 7 - k];
            end else begin
                p.a = v[8*k + j];
                p.b = v[8*(7-k) + j];
            end
            p.last = (i == 31);
            expQ.push_back(p);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last accepted write.
    task automatic writeBlock(input logic [DW-1:0] v [64], input int gapPct, input int nw);
        for (int w = 0; w < nw; w++) begin
            int budget;
            int r;
            int c;
            budget = 0;
            r = w / 4;
            c = w % 4;
            while (gapPct != 0 && $urandom_range(99) < gapPct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_page  = 3'(r);
            in_count = 2'(c);
            in_a     = v[8*r + c];
            in_b     = v[8*r + 7 - c];
            while (!in_ready && budget < 2000) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                $display("FAIL write_timeout in_ready=%b required=1", in_ready);
                errors++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; init = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_page = '0; in_count = '0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (in_ready !== 1'b1)  begin $display("FAIL reset_in_ready got=%b exp=1", in_ready); errors++; end
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", out_valid); errors++; end
        if (out_last !== 1'b0)  begin $display("FAIL reset_out_last got=%b exp=0", out_last); errors++; end
        if (out_a !== '0)       begin $display("FAIL reset_out_a got=%h exp=0", out_a); errors++; end
        if (out_b !== '0)       begin $display("FAIL reset_out_b got=%h exp=0", out_b); errors++; end
        if (occ !== '0)         begin $display("FAIL reset_occ got=%0d exp=0", occ); errors++; end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single(input bit useBypass);
        logic [DW-1:0] v [64];
        pairT obs;
        pairT ex;
        bypass    = useBypass;
        out_ready = 1'b0;
        makeBlock(1'b1, v);
        writeBlock(v, 0, 32);
        checks += 2;
        if (out_valid !== 1'b0) begin $display("FAIL single_early_valid got=%b exp=0", out_valid); errors++; end
        if (occ !== OW'(1))     begin $display("FAIL single_occ got=%0d exp=1", occ); errors++; end
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            obs = {out_last, out_a, out_b};
            ex  = expQ.pop_front();
            checks += 2;
            if (out_valid !== 1'b1) begin $display("FAIL single_valid i=%0d got=%b exp=1", i, out_valid); errors++; end
            if (obs !== ex) begin
                $display("FAIL single_pair bypass=%0d i=%0d got a=%0d b=%0d last=%b exp a=%0d b=%0d last=%b",
                         useBypass, i, obs.a, obs.b, obs.last, ex.a, ex.b, ex.last);
                errors++;
            end else begin
                $display("pair bypass=%0d i=%0d a=%0d b=%0d last=%b", useBypass, i, obs.a, obs.b, obs.last);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin $display("FAIL single_drained_valid got=%b exp=0", out_valid); errors++; end
        if (occ !== '0)         begin $display("FAIL single_drained_occ got=%0d exp=0", occ); errors++; end
        bypass = 1'b0;
    endtask

    task automatic test_fill;
        logic [DW-1:0] v [64];
        pairT obs;
        pairT ex;
        int   got;
        int   cyc;
        out_ready = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            makeBlock(1'b0, v);
            writeBlock(v, 0, 32);
        end
        checks += 2;
        if (occ !== OW'(NBANK)) begin $display("FAIL fill_occ got=%0d exp=%0d", occ, NBANK); errors++; end
        if (in_ready !== 1'b0)  begin $display("FAIL fill_in_ready got=%b exp=0", in_ready); errors++; end
        // A final pair of a fifth block is held while full; it must be ignored.
        in_valid = 1'b1; in_page = 3'd7; in_count = 2'd3;
        in_a = DW'($urandom); in_b = DW'($urandom);
        repeat (6) @(negedge clk);
        checks++;
        if (occ !== OW'(NBANK)) begin $display("FAIL fill_held_occ got=%0d exp=%0d", occ, NBANK); errors++; end
        in_valid = 1'b0;
        got = 0;
        cyc = 0;
        while (got < 32*NBANK && cyc < 1000) begin
            out_ready = 1'b1;
            if (out_valid) begin
                obs = {out_last, out_a, out_b};
                ex  = expQ.pop_front();
                checks++;
                if (obs !== ex) begin
                    $display("FAIL fill_pair n=%0d got a=%h b=%h last=%b exp a=%h b=%h last=%b",
                             got, obs.a, obs.b, obs.last, ex.a, ex.b, ex.last);
                    errors++;
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks += 2;
        if (got != 32*NBANK) begin $display("FAIL fill_drain_timeout got=%0d exp=%0d", got, 32*NBANK); errors++; end
        if (occ !== '0)      begin $display("FAIL fill_final_occ got=%0d exp=0", occ); errors++; end
        $display("test_fill pairs=%0d", got);
    endtask

    task automatic test_boundary;
        logic [DW-1:0] v1 [64];
        logic [DW-1:0] v2 [64];
        pairT obs;
        pairT ex;
        makeBlock(1'b0, v1);
        makeBlock(1'b0, v2);
        out_ready = 1'b1;
        for (int n = 0; n < 97; n++) begin
            if (n < 64) begin
                int w;
                int r;
                int c;
                w = n % 32;
                r = w / 4;
                c = w % 4;
                in_valid = 1'b1;
                in_page  = 3'(r);
                in_count = 2'(c);
                in_a     = (n < 32) ? v1[8*r + c] : v2[8*r + c];
                in_b     = (n < 32) ? v1[8*r + 7 - c] : v2[8*r + 7 - c];
            end else begin
                in_valid = 1'b0;
            end
            if (n == 64) begin
                checks++;
                if (occ !== OW'(1)) begin $display("FAIL boundary_occ got=%0d exp=1", occ); errors++; end
            end
            if (n >= 33) begin
                obs = {out_last, out_a, out_b};
                ex  = expQ.pop_front();
                checks += 2;
                if (out_valid !== 1'b1) begin $display("FAIL boundary_bubble n=%0d got=%b exp=1", n, out_valid); errors++; end
                if (obs !== ex) begin
                    $display("FAIL boundary_pair n=%0d got a=%h b=%h last=%b exp a=%h b=%h last=%b",
                             n - 33, obs.a, obs.b, obs.last, ex.a, ex.b, ex.last);
                    errors++;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin $display("FAIL boundary_end_valid got=%b exp=0", out_valid); errors++; end
        $display("test_boundary done");
    endtask

    task automatic test_random;
        fork
            begin
                logic [DW-1:0] v [64];
                for (int b = 0; b < 16; b++) begin
                    makeBlock(1'b0, v);
                    writeBlock(v, 25, 32);
                end
            end
            begin
                int   got;
                int   cyc;
                bit   holdPend;
                pairT held;
                pairT obs;
                pairT ex;
                got = 0;
                cyc = 0;
                holdPend = 1'b0;
                while (got < 512 && cyc < 20000) begin
                    out_ready = 1'($urandom_range(1));
                    obs = {out_last, out_a, out_b};
                    if (holdPend) begin
                        checks++;
                        if (out_valid !== 1'b1 || obs !== held) begin
                            $display("FAIL random_hold got v=%b a=%h b=%h exp v=1 a=%h b=%h", out_valid, obs.a, obs.b, held.a, held.b);
                            errors++;
                        end
                    end
                    holdPend = 1'b0;
                    if (out_valid) begin
                        if (out_ready) begin
                            checks++;
                            if (expQ.size() == 0) begin
                                $display("FAIL random_extra got a=%h b=%h exp none", obs.a, obs.b);
                                errors++;
                            end else begin
                                ex = expQ.pop_front();
                                if (obs !== ex) begin
                                    $display("FAIL random_pair n=%0d got a=%h b=%h last=%b exp a=%h b=%h last=%b",
                                             got, obs.a, obs.b, obs.last, ex.a, ex.b, ex.last);
                                    errors++;
                                end
                            end
                            got++;
                        end else begin
                            holdPend = 1'b1;
                            held     = obs;
                        end
                    end
                    @(negedge clk);
                    cyc++;
                end
                checks++;
                if (got != 512) begin $display("FAIL random_timeout got=%0d exp=512", got); errors++; end
                $display("test_random pairs=%0d cycles=%0d", got, cyc);
            end
        join
        out_ready = 1'b0;
    endtask

    task automatic test_rst_init;
        logic [DW-1:0] v [64];
        pairT obs;
        pairT ex;
        int   got;
        int   cyc;
        for (int ph = 0; ph < 2; ph++) begin
            out_ready = 1'b0;
            makeBlock(1'b0, v); writeBlock(v, 0, 32);
            makeBlock(1'b0, v); writeBlock(v, 0, 32);
            if (ph == 0) begin
                makeBlock(1'b0, v); writeBlock(v, 0, 10);
                #2 rst = 1'b1;
                #1;
            end else begin
                repeat (10) begin
                    out_ready = 1'b1;
                    @(negedge clk);
                end
                init = 1'b1; in_valid = 1'b1; in_page = 3'd7; in_count = 2'd3;
                @(negedge clk);
                init = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            end
            checks += 3;
            if (occ !== '0)         begin $display("FAIL clear%0d_occ got=%0d exp=0", ph, occ); errors++; end
            if (out_valid !== 1'b0) begin $display("FAIL clear%0d_out_valid got=%b exp=0", ph, out_valid); errors++; end
            if (in_ready !== 1'b1)  begin $display("FAIL clear%0d_in_ready got=%b exp=1", ph, in_ready); errors++; end
            if (ph == 0) begin
                @(negedge clk);
                rst = 1'b0;
            end
            expQ.delete();
            makeBlock(1'b0, v);
            writeBlock(v, 0, 32);
            got = 0;
            cyc = 0;
            while (got < 32 && cyc < 200) begin
                out_ready = 1'b1;
                if (out_valid) begin
                    obs = {out_last, out_a, out_b};
                    ex  = expQ.pop_front();
                    checks++;
                    if (obs !== ex) begin
                        $display("FAIL clear%0d_pair n=%0d got a=%h b=%h last=%b exp a=%h b=%h last=%b",
                                 ph, got, obs.a, obs.b, obs.last, ex.a, ex.b, ex.last);
                        errors++;
                    end
                    got++;
                end
                @(negedge clk);
                cyc++;
            end
            out_ready = 1'b0;
            checks++;
            if (got != 32) begin $display("FAIL clear%0d_timeout got=%0d exp=32", ph, got); errors++; end
            $display("test_rst_init phase=%0d pairs=%0d", ph, got);
        end
    endtask

    initial begin
        test_reset();
        test_single(1'b0);
        test_fill();
        test_boundary();
        test_random();
        test_rst_init();
`ifdef AQ_DJPEG_TBUF_BYPASS_EN
        test_single(1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
